// File: rtl/udt_hs_ctrl.sv
// UDT-style two-way handshake controller.
// Accepts first/second handshake requests and emits the matching responses.
module udt_hs_ctrl #(
  parameter int          TIMEOUT  = 1024,
  parameter logic [31:0] ISN_SEED = 32'h1234_5678
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        listen_en,
  input  logic        close,
  input  logic        client_type_en,
  input  logic [31:0] client_type,
  input  logic [31:0] client_sock_id,
  output logic        client_type_ready,
  output logic        serve_type_en,
  input  logic        serve_ready,
  output logic [31:0] serve_type,
  output logic [31:0] serve_isn,
  output logic [31:0] serve_sock_id,
  output logic        connected,
  output logic        timeout_err,
  output logic [15:0] drop_cnt
);

  typedef enum logic [2:0] {
    IDLE, LISTEN, RESP1, WAIT2, RESP2, CONN
  } state_t;

  localparam int          TW   = $clog2(TIMEOUT + 1);
  localparam logic [31:0] TAPS = 32'h8020_0003;
  // a zero seed would lock the LFSR up
  localparam logic [31:0] SEED =
    (ISN_SEED == 32'h0) ? 32'h1 : ISN_SEED;

  state_t        state, nxt;
  logic [TW-1:0] tcnt;
  logic [31:0]   lfsr;
  logic          acc, consume, is_first;
  logic          is_second, sock_ok, take, tmo;

  assign acc       = client_type_en && client_type_ready;
  assign consume   = serve_type_en && serve_ready;
  assign is_first  = client_type == 32'h0;
  assign is_second = client_type == 32'hffff_ffff;
  assign sock_ok   = client_sock_id == serve_sock_id;

  assign take = listen_en && acc &&
    ((state == LISTEN && is_first) ||
     (state == WAIT2 &&
      (is_first || (is_second && sock_ok))));

  assign tmo = listen_en && state == WAIT2 &&
    tcnt == TW'(TIMEOUT - 1) && !take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (!listen_en) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    nxt = LISTEN;
        LISTEN:  if (take) nxt = RESP1;
        RESP1:   if (consume) nxt = WAIT2;
        WAIT2: begin
          if (take)     nxt = is_first ? RESP1 : RESP2;
          else if (tmo) nxt = LISTEN;
        end
        RESP2:   if (consume) nxt = CONN;
        CONN:    if (close) nxt = LISTEN;
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    client_type_ready = 1'b0;
    serve_type_en     = 1'b0;
    serve_type        = 32'h0;
    connected         = 1'b0;
    unique case (1'b1)
      state == LISTEN,
      state == WAIT2: client_type_ready = 1'b1;
      state == RESP1: begin
        serve_type_en = 1'b1;
        serve_type    = 32'h1;
      end
      state == RESP2: begin
        serve_type_en = 1'b1;
        serve_type    = 32'hffff_ffff;
      end
      state == CONN:  connected = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr          <= SEED;
      tcnt          <= '0;
      serve_isn     <= 32'h0;
      serve_sock_id <= 32'h0;
      timeout_err   <= 1'b0;
      drop_cnt      <= 16'h0;
    end else begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : 32'h0);
      // counter runs only while waiting for the second request
      if (state == WAIT2) tcnt <= tcnt + TW'(1);
      else                tcnt <= '0;
      if (state == LISTEN && take) begin
        serve_isn     <= lfsr;
        serve_sock_id <= client_sock_id;
      end
      timeout_err <= tmo;
      if (client_type_en && !take &&
          drop_cnt != 16'hffff)
        drop_cnt <= drop_cnt + 16'h1;
    end
  end

endmodule
